// File: rtl/duty_seq_pkg.sv
// Shared types and defaults for the motor duty sequencer.
// The FSM walks IDLE -> LEFT -> RIGHT, one adder pass per duty.
package duty_seq_pkg;

  localparam int DUTY_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } duty_seq_state_t;

endpackage

// File: rtl/saturating_adder_signed_unsigned.sv
// Unsigned W-bit operand plus signed (W+1)-bit operand.
// The sum is clamped to the unsigned range [0, 2^W-1].
module saturating_adder_signed_unsigned #(
  parameter int UNSIGNED_WIDTH = 8
) (
  input  logic        [UNSIGNED_WIDTH-1:0] a,
  input  logic signed [UNSIGNED_WIDTH:0]   b,
  output logic        [UNSIGNED_WIDTH-1:0] sum
);

  localparam int W = UNSIGNED_WIDTH;

  // W+2 signed bits hold every sum from -2^W to 2^(W+1)-2 without wrap.
  logic signed [W+1:0] full;

  always_comb begin
    full = $signed({2'b00, a}) + $signed({b[W], b});
    if (full < 0) begin
      sum = '0;
    end else if (full > $signed({2'b00, {W{1'b1}}})) begin
      sum = {W{1'b1}};
    end else begin
      sum = full[W-1:0];
    end
  end

endmodule

// File: rtl/motor_duty_sequencer.sv
// Turns a PID correction into a left/right duty pair using one shared
// saturating adder, committing both duties together on the same edge.
module motor_duty_sequencer
  import duty_seq_pkg::*;
#(
  parameter int UNSIGNED_WIDTH = DUTY_WIDTH_DEFAULT
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic        [UNSIGNED_WIDTH-1:0] base_duty_in,
  input  logic signed [UNSIGNED_WIDTH:0]   correction_in,
  input  logic                        correction_valid_in,
  input  logic                        stop_in,
  output logic                        ready_out,
  output logic        [UNSIGNED_WIDTH-1:0] left_duty_out,
  output logic        [UNSIGNED_WIDTH-1:0] right_duty_out,
  output logic                        duty_valid_out
);

  localparam int W = UNSIGNED_WIDTH;

  duty_seq_state_t state_reg, state_next;

  logic        [W-1:0] base_reg;
  logic signed [W:0]   corr_reg;
  logic        [W-1:0] left_shadow_reg;
  logic signed [W:0]   adder_b;
  logic        [W-1:0] adder_sum;
  logic                accept;

  // -(-2^W) does not fit in W+1 signed bits; clamp it to the largest positive.
  function automatic logic signed [W:0] neg(input logic signed [W:0] x);
    logic signed [W+1:0] t;
    t = -$signed({x[W], x});
    if (t > $signed({2'b00, {W{1'b1}}})) begin
      return $signed({1'b0, {W{1'b1}}});
    end
    return t[W:0];
  endfunction

  assign ready_out = (state_reg == IDLE) && !stop_in;
  assign accept    = ready_out && correction_valid_in;
  assign adder_b   = (state_reg == RIGHT) ? neg(corr_reg) : corr_reg;

  saturating_adder_signed_unsigned #(
    .UNSIGNED_WIDTH(W)
  ) u_adder (
    .a   (base_reg),
    .b   (adder_b),
    .sum (adder_sum)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (stop_in) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = LEFT;
        LEFT:    state_next = RIGHT;
        RIGHT:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      base_reg        <= '0;
      corr_reg        <= '0;
      left_shadow_reg <= '0;
      left_duty_out   <= '0;
      right_duty_out  <= '0;
      duty_valid_out  <= 1'b0;
    end else if (stop_in) begin
      left_duty_out  <= '0;
      right_duty_out <= '0;
      duty_valid_out <= 1'b0;
    end else begin
      duty_valid_out <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            base_reg <= base_duty_in;
            corr_reg <= correction_in;
          end
        end
        LEFT: begin
          left_shadow_reg <= adder_sum;
        end
        RIGHT: begin
          left_duty_out  <= left_shadow_reg;
          right_duty_out <= adder_sum;
          duty_valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_duty_sequencer.sv
// Directed bench for motor_duty_sequencer with a per-cycle reference model
// built from the duty equations (left = base+corr, right = base-corr, clamped).
module tb_motor_duty_sequencer;

  localparam int W = 8;

  logic               clk;
  logic               rst_n;
  logic        [W-1:0] base;
  logic signed [W:0]   corr;
  logic               cvalid;
  logic               stop;
  logic               ready;
  logic        [W-1:0] left_duty;
  logic        [W-1:0] right_duty;
  logic               dvalid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit compare_on = 0;

  motor_duty_sequencer #(.UNSIGNED_WIDTH(W)) dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .base_duty_in        (base),
    .correction_in       (corr),
    .correction_valid_in (cvalid),
    .stop_in             (stop),
    .ready_out           (ready),
    .left_duty_out       (left_duty),
    .right_duty_out      (right_duty),
    .duty_valid_out      (dvalid)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int x);
    if (x < 0) return 0;
    if (x > (1 << W) - 1) return (1 << W) - 1;
    return x;
  endfunction

  // Reference model: a request occupies two edges after acceptance, then
  // both clamped duties appear together with a one-cycle valid.
  int m_cnt, m_left, m_right, m_valid, p_left, p_right;

  always @(posedge clk or negedge rst_n) begin : model
    int nc, nl, nr, nv, pl, pr;
    nc = m_cnt; nl = m_left; nr = m_right; nv = 0; pl = p_left; pr = p_right;
    if (!rst_n) begin
      nc = 0; nl = 0; nr = 0; pl = 0; pr = 0;
    end else if (stop) begin
      nc = 0; nl = 0; nr = 0;
    end else if (nc == 0) begin
      if (cvalid) begin
        pl = sat(int'(base) + int'(corr));
        pr = sat(int'(base) - int'(corr));
        nc = 2;
      end
    end else begin
      nc = nc - 1;
      if (nc == 0) begin
        nl = pl; nr = pr; nv = 1;
      end
    end
    m_cnt   <= nc;
    m_left  <= nl;
    m_right <= nr;
    m_valid <= nv;
    p_left  <= pl;
    p_right <= pr;
  end

  bit prev_dvalid = 0;
  always @(negedge clk) begin
    if (compare_on) begin
      check("left", int'(left_duty), m_left);
      check("right", int'(right_duty), m_right);
      check("valid", int'(dvalid), m_valid);
      check("ready", int'(ready), int'((m_cnt == 0) && !stop));
      check("valid_not_back_to_back", int'(prev_dvalid && dvalid), 0);
      prev_dvalid = dvalid;
    end
  end

  // Drive a single request and check the committed pair two edges later.
  task automatic req_and_check(input int b, input int c, input int el, input int er);
    @(posedge clk); #2;
    base = b[W-1:0]; corr = c[W:0]; cvalid = 1;
    @(posedge clk); #2;                      // E0: accepted
    cvalid = 0;
    @(posedge clk);                          // E1
    @(posedge clk); #1;                      // E2: commit
    check("lit_left", int'(left_duty), el);
    check("lit_right", int'(right_duty), er);
    check("lit_pulse", int'(dvalid), 1);
    @(posedge clk); #1;
    check("lit_pulse_end", int'(dvalid), 0);
    check("lit_hold_left", int'(left_duty), el);
  endtask

  int pulses[$];
  bit found;

  initial begin
    rst_n = 0; stop = 0; cvalid = 0; base = '0; corr = '0;
    compare_on = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_left", int'(left_duty), 0);
    check("rst_right", int'(right_duty), 0);
    check("rst_valid", int'(dvalid), 0);
    check("rst_ready", int'(ready), 1);
    #1 rst_n = 1;

    req_and_check(100, -10, 90, 110);
    req_and_check(250, 20, 255, 230);
    req_and_check(5, 100, 105, 0);
    req_and_check(0, -256, 0, 255);

    // Stop during LEFT discards the request.
    @(posedge clk); #2;
    base = 8'd40; corr = 9'sd7; cvalid = 1;
    @(posedge clk); #2;                      // accepted
    stop = 1; cvalid = 0;
    @(posedge clk); #1;
    check("stop_left", int'(left_duty), 0);
    check("stop_right", int'(right_duty), 0);
    check("stop_valid", int'(dvalid), 0);
    check("stop_ready", int'(ready), 0);
    #1 cvalid = 1;                           // ignored while stopped
    @(posedge clk); #1;
    check("stop_no_pulse", int'(dvalid), 0);
    check("stop_ready_held", int'(ready), 0);
    #1 stop = 0; cvalid = 0;
    req_and_check(40, 7, 47, 33);

    // Continuous requests with changing data.
    @(posedge clk); #2;
    cvalid = 1; base = 8'd20; corr = -9'sd3;
    for (int k = 1; k < 12; k++) begin
      @(posedge clk); #1;
      if (dvalid) pulses.push_back(cyc);
      #1;
      base = 8'(20 + 13 * k);
      corr = 9'(k * 7 - 30);
    end
    check("stream_pulse_count", pulses.size() >= 3 ? 1 : 0, 1);
    for (int i = 1; i < pulses.size(); i++)
      check("stream_spacing", pulses[i] - pulses[i-1], 3);

    // Reset asserted mid-RIGHT: no commit.
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(posedge clk); #2;
      if (m_cnt == 1) found = 1;
    end
    check("reach_right_in_budget", int'(found), 1);
    rst_n = 0;
    #1;
    check("midrst_left", int'(left_duty), 0);
    check("midrst_right", int'(right_duty), 0);
    check("midrst_valid", int'(dvalid), 0);
    cvalid = 0;
    @(posedge clk); #1;
    check("midrst_no_commit", int'(dvalid), 0);
    #1 rst_n = 1;
    req_and_check(128, 127, 255, 1);

    repeat (2) @(posedge clk);
    compare_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
